// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt pending latch.
// N channels, ID_W-bit acknowledge index, default synchroniser depth.
package irq_pkg;

    localparam int N           = 8;
    localparam int ID_W        = 3;
    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } ack_state_t;

endpackage

// File: rtl/bit_sync.sv
// Single-bit STAGES-deep flop chain for an asynchronous input.
// Ports: clk, rst_n (async active-low), d (raw), q (synchronised).
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_pending_latch.sv
// Synchronises N request lines, latches rising edges as pending bits,
// masks them toward the priority encoder and clears them on acknowledge.
// Ports: clk, rst_n, req_in, mask_wr/mask_in, pend_o, irq_o,
//        ack_valid/ack_id/ack_ready handshake, ack_err_o pulse.
// Optional: define IRQ_OVERRUN_EN to add the sticky overrun_o flags.
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_in,
    input  logic            mask_wr,
    input  logic [N-1:0]    mask_in,
    output logic [N-1:0]    pend_o,
    output logic            irq_o,
    input  logic            ack_valid,
    input  logic [ID_W-1:0] ack_id,
    output logic            ack_ready,
    output logic            ack_err_o
`ifdef IRQ_OVERRUN_EN
   ,output logic [N-1:0]    overrun_o
`endif
);

    localparam logic [ID_W:0] N_LIM = (ID_W+1)'(N);

    logic [N-1:0] sync_out;
    logic [N-1:0] sync_prev;
    logic [N-1:0] rise;
    logic [N-1:0] pending;
    logic [N-1:0] pending_d;
    logic [N-1:0] mask;
    logic [N-1:0] clr;
    logic [STAGES:0] warm;
    logic            accept;
    logic            id_ok;
    logic            hit;

    ack_state_t state;
    ack_state_t state_d;

    for (genvar g = 0; g < N; g++) begin : g_sync
        bit_sync #(
            .STAGES (STAGES)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (req_in[g]),
            .q     (sync_out[g])
        );
    end

    // The chain and history flops leave reset at 0, so a line already
    // high at release would look like a rising edge. Edges are ignored
    // until the history flop holds a real sample of the line.
    assign rise = warm[STAGES] ? (sync_out & ~sync_prev) : '0;

    assign id_ok  = {1'b0, ack_id} < N_LIM;
    assign hit    = id_ok && pending[ack_id];
    assign accept = ack_valid && ack_ready;
    assign clr    = (accept && id_ok) ? (N'(1) << ack_id) : '0;

    // New edge is OR-ed in after the clear so a same-cycle edge wins.
    assign pending_d = (pending & ~clr) | rise;

    always_comb begin
        state_d   = state;
        ack_ready = 1'b0;
        unique case (state)
            ST_IDLE: begin
                ack_ready = 1'b1;
                if (ack_valid) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sync_prev <= '0;
            pending   <= '0;
            mask      <= '1;
            warm      <= '0;
            ack_err_o <= 1'b0;
        end else begin
            state     <= state_d;
            sync_prev <= sync_out;
            pending   <= pending_d;
            warm      <= {warm[STAGES-1:0], 1'b1};
            ack_err_o <= accept && !hit;
            if (mask_wr) begin
                mask <= mask_in;
            end
        end
    end

    assign pend_o = pending & mask;
    assign irq_o  = |pend_o;

`ifdef IRQ_OVERRUN_EN
    logic [N-1:0] overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= '0;
        end else begin
            overrun <= (overrun & ~clr) | (rise & pending);
        end
    end

    assign overrun_o = overrun;
`endif

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch.
// Expected pend_o values are queued at stimulus time and popped at check.
module tb_irq_pending_latch;
    import irq_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_in;
    logic            mask_wr;
    logic [N-1:0]    mask_in;
    logic [N-1:0]    pend_o;
    logic            irq_o;
    logic            ack_valid;
    logic [ID_W-1:0] ack_id;
    logic            ack_ready;
    logic            ack_err_o;
`ifdef IRQ_OVERRUN_EN
    logic [N-1:0]    overrun_o;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp;

    always #5 clk = ~clk;

    irq_pending_latch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .pend_o    (pend_o),
        .irq_o     (irq_o),
        .ack_valid (ack_valid),
        .ack_id    (ack_id),
        .ack_ready (ack_ready),
        .ack_err_o (ack_err_o)
`ifdef IRQ_OVERRUN_EN
       ,.overrun_o (overrun_o)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_in = '1; mask_wr = 1'b0; mask_in = '0;
        ack_valid = 1'b0; ack_id = '0;
        exp_q.push_back(8'h00);
        tick(); tick();
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL rst_pend got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        total_cnt++;
        if (irq_o !== 1'b0) $display("FAIL rst_irq got=%b exp=0", irq_o);
        else pass_cnt++;
        total_cnt++;
        if (ack_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", ack_ready);
        else pass_cnt++;
        total_cnt++;
        if (ack_err_o !== 1'b0) $display("FAIL rst_err got=%b exp=0", ack_err_o);
        else pass_cnt++;
        rst_n = 1'b1;
        exp_q.push_back(8'h00);
        repeat (5) tick();
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL rel_pend got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        total_cnt++;
        if (irq_o !== 1'b0) $display("FAIL rel_irq got=%b exp=0", irq_o);
        else pass_cnt++;
        req_in = '0;
        repeat (4) tick();
    endtask

    task automatic test_latency();
        req_in[5] = 1'b1;
        tick(); tick();
        exp_q.push_back(8'h00);
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL lat_early got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        exp_q.push_back(8'h20);
        tick();
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL lat_pend got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        total_cnt++;
        if (irq_o !== 1'b1) $display("FAIL lat_irq got=%b exp=1", irq_o);
        else pass_cnt++;
        ack_valid = 1'b1; ack_id = 3'd5;
        exp_q.push_back(8'h00);
        tick();
        ack_valid = 1'b0;
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL lat_ack got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        total_cnt++;
        if (ack_ready !== 1'b0) $display("FAIL lat_settle got=%b exp=0", ack_ready);
        else pass_cnt++;
        total_cnt++;
        if (ack_err_o !== 1'b0) $display("FAIL lat_err got=%b exp=0", ack_err_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ack_ready !== 1'b1) $display("FAIL lat_ready got=%b exp=1", ack_ready);
        else pass_cnt++;
        req_in[5] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_mask();
        mask_wr = 1'b1; mask_in = 8'hFE;
        tick();
        mask_wr = 1'b0;
        req_in[0] = 1'b1;
        repeat (3) tick();
        exp_q.push_back(8'h00);
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL mask_hide got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        total_cnt++;
        if (irq_o !== 1'b0) $display("FAIL mask_irq got=%b exp=0", irq_o);
        else pass_cnt++;
        mask_wr = 1'b1; mask_in = 8'hFF;
        exp_q.push_back(8'h01);
        tick();
        mask_wr = 1'b0;
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL mask_show got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        total_cnt++;
        if (irq_o !== 1'b1) $display("FAIL mask_irq1 got=%b exp=1", irq_o);
        else pass_cnt++;
        ack_valid = 1'b1; ack_id = 3'd0;
        exp_q.push_back(8'h00);
        tick();
        ack_valid = 1'b0;
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL mask_clr got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        tick();
        req_in[0] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_race();
        req_in[3] = 1'b1;
        repeat (3) tick();
        exp_q.push_back(8'h08);
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL race_set got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        req_in[3] = 1'b0;
        repeat (3) tick();
        req_in[3] = 1'b1;
        tick(); tick();
        ack_valid = 1'b1; ack_id = 3'd3;
        exp_q.push_back(8'h08);
        tick();
        ack_valid = 1'b0;
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL race_keep got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        total_cnt++;
        if (ack_err_o !== 1'b0) $display("FAIL race_err got=%b exp=0", ack_err_o);
        else pass_cnt++;
        total_cnt++;
        if (ack_ready !== 1'b0) $display("FAIL race_settle got=%b exp=0", ack_ready);
        else pass_cnt++;
`ifdef IRQ_OVERRUN_EN
        total_cnt++;
        if (overrun_o !== 8'h08) $display("FAIL race_ovr got=%h exp=08", overrun_o);
        else pass_cnt++;
`endif
        tick();
        ack_valid = 1'b1; ack_id = 3'd3;
        exp_q.push_back(8'h00);
        tick();
        ack_valid = 1'b0;
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL race_clr got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
`ifdef IRQ_OVERRUN_EN
        total_cnt++;
        if (overrun_o !== 8'h00) $display("FAIL race_ovr_clr got=%h exp=00", overrun_o);
        else pass_cnt++;
`endif
        tick();
        req_in[3] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_error();
        req_in[0] = 1'b1;
        repeat (3) tick();
        ack_valid = 1'b1; ack_id = 3'd6;
        exp_q.push_back(8'h01);
        tick();
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL err_pend got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        total_cnt++;
        if (ack_err_o !== 1'b1) $display("FAIL err_pulse got=%b exp=1", ack_err_o);
        else pass_cnt++;
        total_cnt++;
        if (ack_ready !== 1'b0) $display("FAIL err_settle got=%b exp=0", ack_ready);
        else pass_cnt++;
        ack_id = 3'd0;
        exp_q.push_back(8'h01);
        tick();
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL err_ignore got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        total_cnt++;
        if (ack_err_o !== 1'b0) $display("FAIL err_one got=%b exp=0", ack_err_o);
        else pass_cnt++;
        total_cnt++;
        if (ack_ready !== 1'b1) $display("FAIL err_ready got=%b exp=1", ack_ready);
        else pass_cnt++;
        exp_q.push_back(8'h00);
        tick();
        ack_valid = 1'b0;
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL err_held got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        total_cnt++;
        if (ack_err_o !== 1'b0) $display("FAIL err_ok got=%b exp=0", ack_err_o);
        else pass_cnt++;
        tick();
        req_in[0] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_multi();
        logic [ID_W-1:0] ids [3];
        logic [N-1:0]    exps [3];
        ids  = '{3'd7, 3'd2, 3'd0};
        exps = '{8'h05, 8'h01, 8'h00};
        req_in = 8'h85;
        repeat (3) tick();
        exp_q.push_back(8'h85);
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL multi_set got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            ack_valid = 1'b1; ack_id = ids[i];
            exp_q.push_back(exps[i]);
            tick();
            ack_valid = 1'b0;
            exp = exp_q.pop_front(); total_cnt++;
            if (pend_o !== exp)
                $display("FAIL multi_ack%0d got=%h exp=%h", i, pend_o, exp);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (irq_o !== 1'b0) $display("FAIL multi_irq got=%b exp=0", irq_o);
        else pass_cnt++;
        req_in = '0;
        repeat (3) tick();
    endtask

    task automatic test_midreset();
        req_in[1] = 1'b1;
        repeat (3) tick();
        ack_valid = 1'b1; ack_id = 3'd1;
        tick();
        #2;
        rst_n = 1'b0;
        exp_q.push_back(8'h00);
        #1;
        exp = exp_q.pop_front(); total_cnt++;
        if (pend_o !== exp) $display("FAIL mrst_pend got=%h exp=%h", pend_o, exp);
        else pass_cnt++;
        total_cnt++;
        if (ack_ready !== 1'b1) $display("FAIL mrst_ready got=%b exp=1", ack_ready);
        else pass_cnt++;
        ack_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        req_in = '0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_mask();
        test_race();
        test_error();
        test_multi();
        test_midreset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
